// File: rtl/mem_responder.sv
// Word-addressed instruction/data memory for a single-cycle CPU model.
// A LOAD phase accepts preload words; RUN serves fetches, loads and stores with 1-cycle latency.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter int          ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_addr,
  output logic [31:0]       instr_in,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_out,
  input  logic              data_rd_wr,
  output logic [31:0]       data_in,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic              running,
  output logic              err_range,
  output logic              err_align,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic {LOAD, RUN} state_t;

  // One past the last byte of the window, widened so the compare cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));

  state_t state, state_nxt;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic [31:0]       i_off, d_off;
  logic [ADDR_W-1:0] i_idx, d_idx;
  logic              i_ok, d_ok;
  logic              wr_en, rd_en;
  logic              bad_align;

  assign i_off = instr_addr - BASE_ADDR;
  assign d_off = data_addr - BASE_ADDR;
  assign i_idx = ADDR_W'(i_off >> 2);
  assign d_idx = ADDR_W'(d_off >> 2);
  assign i_ok  = (instr_addr >= BASE_ADDR) && ({1'b0, instr_addr} < LIMIT);
  assign d_ok  = (data_addr  >= BASE_ADDR) && ({1'b0, data_addr}  < LIMIT);

  assign running    = (state == RUN);
  assign load_ready = (state == LOAD);
  assign wr_en      = running && !data_rd_wr && d_ok;
  assign rd_en      = running &&  data_rd_wr && d_ok;
  assign bad_align  = (instr_addr[1:0] != 2'b00) || (data_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (state == LOAD && load_done) state_nxt = RUN;
  end

  // NOTE: the array is deliberately not reset -- contents must survive reset, and a
  // reset array would also defeat RAM inference. Reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && load_valid) mem[load_addr] <= load_data;
      else if (wr_en)                  mem[d_idx]     <= data_out;
    end
  end

  // Read ports are write-first: a same-cycle store is forwarded to both ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_in <= 32'h0;
      data_in  <= 32'h0;
    end else if (running) begin
      if (!i_ok)                         instr_in <= 32'h0;
      else if (wr_en && d_idx == i_idx)  instr_in <= data_out;
      else                               instr_in <= mem[i_idx];
      if (wr_en)      data_in <= data_out;
      else if (rd_en) data_in <= mem[d_idx];
      else            data_in <= 32'h0;
    end else begin
      instr_in <= 32'h0;
      data_in  <= 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_range <= 1'b0;
      err_align <= 1'b0;
      rd_count  <= 16'h0;
      wr_count  <= 16'h0;
    end else if (running) begin
      if (!i_ok || !d_ok) err_range <= 1'b1;
      if (bad_align)      err_align <= 1'b1;
      if (rd_en && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_en && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic against a
// sparse-array model of the memory window, flags and counters.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h80020000;
  localparam int          AW   = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr_addr, instr_in, data_addr, data_out, data_in, load_data;
  logic          data_rd_wr, load_valid, load_done, load_ready, running;
  logic          err_range, err_align;
  logic [AW-1:0] load_addr;
  logic [15:0]   rd_count, wr_count;

  mem_responder dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr), .data_in(data_in),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_ready(load_ready), .running(running),
    .err_range(err_range), .err_align(err_align),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] exp_instr, exp_data;
  bit          exp_instr_known, exp_data_known;
  bit          exp_running, exp_err_range, exp_err_align;
  logic [15:0] exp_rd, exp_wr;

  function automatic bit in_rng(logic [31:0] a);
    return (a >= BASE) && ((longint'(a) - longint'(BASE)) < (longint'(4) << AW));
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] addr_of(int idx);
    return BASE + 32'(idx) * 32'd4;
  endfunction

  // One clock cycle: drive inputs, advance the model, return at posedge+1.
  task automatic cycle(input bit lv, input logic [AW-1:0] la, input logic [31:0] ld,
                       input bit dn, input logic [31:0] ia, input logic [31:0] da,
                       input bit rw, input logic [31:0] wd);
    bit i_ok, d_ok;
    int k;
    load_valid = lv; load_addr = la; load_data = ld; load_done = dn;
    instr_addr = ia; data_addr = da; data_rd_wr = rw; data_out = wd;
    if (!exp_running) begin
      if (lv) ref_mem[int'(la)] = ld;
      exp_instr = 32'h0; exp_instr_known = 1'b1;
      exp_data  = 32'h0; exp_data_known  = 1'b1;
      if (dn) exp_running = 1'b1;
    end else begin
      i_ok = in_rng(ia);
      d_ok = in_rng(da);
      if (!i_ok || !d_ok) exp_err_range = 1'b1;
      if (ia[1:0] != 2'b00 || da[1:0] != 2'b00) exp_err_align = 1'b1;
      if (!rw) begin
        if (d_ok) begin
          ref_mem[idx_of(da)] = wd;
          if (exp_wr != 16'hFFFF) exp_wr++;
          exp_data = wd; exp_data_known = 1'b1;
        end else begin
          exp_data_known = 1'b0;
        end
      end else if (d_ok) begin
        if (exp_rd != 16'hFFFF) exp_rd++;
        k = idx_of(da);
        exp_data_known = ref_mem.exists(k);
        exp_data = exp_data_known ? ref_mem[k] : 32'h0;
      end else begin
        exp_data = 32'h0; exp_data_known = 1'b1;
      end
      if (!i_ok) begin
        exp_instr = 32'h0; exp_instr_known = 1'b1;
      end else begin
        k = idx_of(ia);
        exp_instr_known = ref_mem.exists(k);
        exp_instr = exp_instr_known ? ref_mem[k] : 32'h0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [31:0] ia, input logic [31:0] da, input bit rw,
                        input logic [31:0] wd);
    cycle(1'b0, '0, 32'h0, 1'b0, ia, da, rw, wd);
  endtask

  task automatic model_reset();
    exp_running = 1'b0; exp_err_range = 1'b0; exp_err_align = 1'b0;
    exp_rd = 16'h0; exp_wr = 16'h0;
    exp_instr = 32'h0; exp_data = 32'h0; exp_instr_known = 1'b1; exp_data_known = 1'b1;
  endtask

  task automatic do_reset();
    load_valid = 1'b0; load_done = 1'b0; data_rd_wr = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Preload idx0/idx1 with CPU ports carrying junk that LOAD must ignore.
  task automatic preload_basic();
    cycle(1'b1, 18'd0, 32'h24090005, 1'b0, 32'h0, 32'h80020001, 1'b0, 32'h11111111);
    cycle(1'b1, 18'd1, 32'h8FA80000, 1'b1, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0; load_addr = '0; load_data = 32'h0; load_done = 1'b0;
    instr_addr = BASE; data_addr = BASE; data_rd_wr = 1'b1; data_out = 32'h0;
    model_reset();
    #3;
    n_cmp++; if (instr_in !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr_in); end
    n_cmp++; if (data_in !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_in); end
    n_cmp++; if ({load_ready, running, err_range, err_align} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctl: got rdy/run/er/ea=%b want 1000", {load_ready, running, err_range, err_align}); end
    n_cmp++; if ({rd_count, wr_count} !== 32'h0) begin
      n_bad++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_preload_fetch();
    do_reset();
    cycle(1'b1, 18'd0, 32'h24090005, 1'b0, 32'h0, 32'h80020001, 1'b0, 32'h11111111);
    n_cmp++; if ({running, load_ready, err_range, err_align, instr_in, data_in, wr_count} !== {4'b0100, 80'h0}) begin
      n_bad++; $display("FAIL load_ignores_cpu: run=%b rdy=%b er=%b ea=%b i=%h d=%h wr=%0d want 0,1,0,0,0,0,0",
                        running, load_ready, err_range, err_align, instr_in, data_in, wr_count); end
    cycle(1'b1, 18'd1, 32'h8FA80000, 1'b1, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0);
    n_cmp++; if ({running, load_ready} !== 2'b10) begin
      n_bad++; $display("FAIL enter_run: got run/rdy=%b%b want 10", running, load_ready); end
    run_op(32'h80020004, BASE, 1'b1, 32'h0);
    n_cmp++; if (instr_in !== 32'h8FA80000) begin n_bad++; $display("FAIL fetch_idx1: got %h want 8fa80000", instr_in); end
    n_cmp++; if (data_in !== 32'h24090005) begin n_bad++; $display("FAIL read_idx0: got %h want 24090005", data_in); end
    // RUN ignores further preload traffic
    cycle(1'b1, 18'd0, 32'h0BADF00D, 1'b1, BASE, BASE, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'h24090005 || running !== 1'b1) begin
      n_bad++; $display("FAIL run_ignores_load: got d=%h run=%b want 24090005 1", data_in, running); end
  endtask

  task automatic test_write_read();
    do_reset();
    preload_basic();
    run_op(BASE, 32'h8011FFFC, 1'b0, 32'hDEADBEEF);
    n_cmp++; if (data_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_first_data: got %h want deadbeef", data_in); end
    run_op(BASE, 32'h8011FFFC, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL readback_top: got %h want deadbeef", data_in); end
    n_cmp++; if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
      n_bad++; $display("FAIL counts_1_1: got rd=%0d wr=%0d want 1/1", rd_count, wr_count); end
    n_cmp++; if (err_range !== 1'b0 || err_align !== 1'b0) begin
      n_bad++; $display("FAIL no_err: got er=%b ea=%b want 0 0", err_range, err_align); end
  endtask

  task automatic test_range();
    run_op(BASE, 32'h80120000, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'h0 || err_range !== 1'b1) begin
      n_bad++; $display("FAIL read_above: got d=%h er=%b want 0 1", data_in, err_range); end
    run_op(BASE, 32'h8001FFFC, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'h0 || rd_count !== 16'd1) begin
      n_bad++; $display("FAIL read_below: got d=%h rd=%0d want 0 1", data_in, rd_count); end
    run_op(32'h80120000, 32'h80120000, 1'b0, 32'h12345678);
    n_cmp++; if (instr_in !== 32'h0 || wr_count !== 16'd1) begin
      n_bad++; $display("FAIL write_above: got i=%h wr=%0d want 0 1", instr_in, wr_count); end
    run_op(BASE, 32'h8011FFFC, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL top_intact: got %h want deadbeef", data_in); end
    run_op(32'h8011FFFC, BASE, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'h24090005 || instr_in !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL base_intact: got d=%h i=%h want 24090005 deadbeef", data_in, instr_in); end
    n_cmp++; if (err_range !== 1'b1 || err_align !== 1'b0) begin
      n_bad++; $display("FAIL range_sticky: got er=%b ea=%b want 1 0", err_range, err_align); end
  endtask

  task automatic test_align();
    do_reset();
    preload_basic();
    run_op(32'h80020005, 32'h80020006, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'h8FA80000 || instr_in !== 32'h8FA80000) begin
      n_bad++; $display("FAIL misaligned_read: got d=%h i=%h want 8fa80000 x2", data_in, instr_in); end
    n_cmp++; if (err_align !== 1'b1 || err_range !== 1'b0) begin
      n_bad++; $display("FAIL align_flags: got ea=%b er=%b want 1 0", err_align, err_range); end
    run_op(BASE, BASE, 1'b1, 32'h0);
    n_cmp++; if (err_align !== 1'b1) begin n_bad++; $display("FAIL align_sticky: got %b want 1", err_align); end
  endtask

  task automatic test_write_first();
    run_op(BASE, BASE, 1'b0, 32'hCAFEF00D);
    n_cmp++; if (instr_in !== 32'hCAFEF00D) begin n_bad++; $display("FAIL fetch_write_first: got %h want cafef00d", instr_in); end
    run_op(32'h80020004, BASE, 1'b1, 32'h0);
    n_cmp++; if (data_in !== 32'hCAFEF00D || instr_in !== 32'h8FA80000) begin
      n_bad++; $display("FAIL after_write: got d=%h i=%h want cafef00d 8fa80000", data_in, instr_in); end
  endtask

  task automatic test_random();
    int idxs[$];
    logic [31:0] ia, da;
    int k;
    do_reset();
    for (int i = 0; i < 8; i++) begin idxs.push_back(i); idxs.push_back((1 << AW) - 1 - i); end
    foreach (idxs[j]) begin
      if ($urandom_range(3) == 0) cycle(1'b0, '0, 32'h0, 1'b0, $urandom, $urandom, 1'(j), $urandom);
      cycle(1'b1, AW'(idxs[j]), $urandom, 1'b0, $urandom, $urandom, 1'b0, $urandom);
    end
    cycle(1'b1, AW'(idxs[0]), $urandom, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      ia = addr_of(idxs[$urandom_range(idxs.size() - 1)]);
      if ($urandom_range(9) == 0) ia = ia + 32'($urandom_range(3));
      k = $urandom_range(11);
      if (k == 0)      da = BASE - 32'd4 * 32'($urandom_range(1, 4));
      else if (k == 1) da = BASE + (32'd4 << AW) + 32'd4 * 32'($urandom_range(3));
      else begin
        da = addr_of(idxs[$urandom_range(idxs.size() - 1)]);
        if (k == 2) da = da + 32'($urandom_range(3));
      end
      if ($urandom_range(15) == 0) ia = 32'hFFFFFFFC;
      run_op(ia, da, 1'($urandom_range(1)), $urandom);
      if (exp_instr_known) begin
        n_cmp++; if (instr_in !== exp_instr) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, instr_in, exp_instr); end
      end
      if (exp_data_known) begin
        n_cmp++; if (data_in !== exp_data) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", n, data_in, exp_data); end
      end
      n_cmp++; if ({err_range, err_align, running} !== {exp_err_range, exp_err_align, 1'b1}) begin
        n_bad++; $display("FAIL rnd_flags[%0d]: got er/ea/run=%b%b%b want %b%b1", n, err_range, err_align, running, exp_err_range, exp_err_align); end
      n_cmp++; if (rd_count !== exp_rd || wr_count !== exp_wr) begin
        n_bad++; $display("FAIL rnd_counts[%0d]: got rd=%0d wr=%0d want %0d/%0d", n, rd_count, wr_count, exp_rd, exp_wr); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] w0, w1;
    w0 = ref_mem[0]; w1 = ref_mem[1];
    // Store to idx0 is set up, then reset arrives before the edge that would commit it.
    instr_addr = BASE; data_addr = BASE; data_rd_wr = 1'b0;
    data_out = ~w0; load_valid = 1'b0; load_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({instr_in, data_in, rd_count, wr_count} !== 96'h0) begin
      n_bad++; $display("FAIL async_reset_data: got i=%h d=%h rd=%0d wr=%0d want all 0", instr_in, data_in, rd_count, wr_count); end
    n_cmp++; if ({load_ready, running, err_range, err_align} !== 4'b1000) begin
      n_bad++; $display("FAIL async_reset_ctl: got %b want 1000", {load_ready, running, err_range, err_align}); end
    @(posedge clk); #1;
    data_rd_wr = 1'b1;
    reset = 1'b0;
    model_reset();
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL post_reset_running: got %b want 0", running); end
    cycle(1'b0, '0, 32'h0, 1'b1, BASE, BASE, 1'b1, 32'h0);
    run_op(32'h80020004, BASE, 1'b1, 32'h0);
    n_cmp++; if (data_in !== w0) begin n_bad++; $display("FAIL mem_kept_idx0: got %h want %h", data_in, w0); end
    n_cmp++; if (instr_in !== w1) begin n_bad++; $display("FAIL mem_kept_idx1: got %h want %h", instr_in, w1); end
  endtask

  initial begin
    test_reset();
    test_preload_fetch();
    test_write_read();
    test_range();
    test_align();
    test_write_first();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
